// File: rtl/tnn_pkg.sv
// Shared types and constants for the TNN threshold-layer sequencer.
package tnn_pkg;

    localparam int TNN_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } tnn_seq_state_t;

    typedef logic [TNN_W-1:0] tnn_opnd_t;

endpackage

// File: rtl/tnn_thr_cmp.sv
// Exact threshold comparator: gt = (a + b) > c, with the sum kept one bit wider
// so an overflowing a+b always counts as greater. Approximate comparator variants
// can replace this module as long as they keep the same ports.
module tnn_thr_cmp
    import tnn_pkg::*;
#(
    parameter int W = TNN_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic         gt_o
);

    logic [W:0] sum_s;

    // Widened sum and unsigned compare against the zero-extended threshold.
    always_comb begin
        sum_s = {1'b0, a_i} + {1'b0, b_i};
        gt_o  = (sum_s > {1'b0, c_i});
    end

endmodule

// File: rtl/tnn_layer_sequencer.sv
// Sequences one TNN threshold layer: captures a sample of N operand triples,
// evaluates one neuron per cycle on a shared comparator, and returns the
// collected decision vector over a valid/ready handshake.
module tnn_layer_sequencer
    import tnn_pkg::*;
#(
    parameter int N_NEURONS = 6,
    parameter int W         = TNN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_NEURONS*W-1:0] in_a,
    input  logic [N_NEURONS*W-1:0] in_b,
    input  logic [N_NEURONS*W-1:0] in_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_NEURONS-1:0]   out_bits,
    output logic                   busy
);

    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

    tnn_seq_state_t           state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_NEURONS*W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [N_NEURONS-1:0]     res_q, res_d;
    logic [N_NEURONS-1:0]     out_bits_q, out_bits_d;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic                     busy_q, busy_d;
    logic [W-1:0]             a_sel_s, b_sel_s, c_sel_s;
    logic                     gt_s;

    // Operand lane mux: pick the triple of the neuron currently addressed by idx.
    always_comb begin
        a_sel_s = {W{1'b0}};
        b_sel_s = {W{1'b0}};
        c_sel_s = {W{1'b0}};
        for (int i = 0; i < N_NEURONS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sel_s = a_q[i*W +: W];
                b_sel_s = b_q[i*W +: W];
                c_sel_s = c_q[i*W +: W];
            end else begin
                a_sel_s = a_sel_s;
            end
        end
    end

    tnn_thr_cmp #(.W(W)) u_cmp (
        .a_i  (a_sel_s),
        .b_i  (b_sel_s),
        .c_i  (c_sel_s),
        .gt_o (gt_s)
    );

    // Next-state, datapath and output decode; outputs follow the next state so they are registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    idx_d   = {IDX_W{1'b0}};
                    res_d   = {N_NEURONS{1'b0}};
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                // Per-bit write enable: only the addressed result bit is updated.
                for (int i = 0; i < N_NEURONS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        res_d[i] = gt_s;
                    end else begin
                        res_d[i] = res_q[i];
                    end
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_EVAL) || (state_d == ST_DONE);
        if (out_valid_d) begin
            out_bits_d = res_d;
        end else begin
            out_bits_d = {N_NEURONS{1'b0}};
        end
    end

    // State, operand, result and output registers; reset discards any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            a_q         <= {(N_NEURONS*W){1'b0}};
            b_q         <= {(N_NEURONS*W){1'b0}};
            c_q         <= {(N_NEURONS*W){1'b0}};
            res_q       <= {N_NEURONS{1'b0}};
            out_bits_q  <= {N_NEURONS{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            res_q       <= res_d;
            out_bits_q  <= out_bits_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;
    assign busy      = busy_q;

endmodule
